// File: rtl/div8_restoring_seq.sv
`timescale 1ns/1ps
// Iterative unsigned restoring divider.
// One quotient bit per clock, produced by a (WIDTH+1)-bit subtract-with-carry-out
// stage (invert + add-with-carry chain, carry-in 1). Carry-out high means the
// shifted partial remainder was >= divisor, which is also the quotient bit.
//
// Handshake: START is sampled only in IDLE or DONE. An accepted START captures
// DIVIDEND/DIVISOR on that edge. BUSY is high for exactly the WIDTH RUN cycles.
// VALID pulses for the single DONE cycle. QUOTIENT/REMAINDER hold until the
// next run finishes. DIV_BY_ZERO updates on the accepted START and then holds.
// START during RUN is ignored.
module div8_restoring_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO,
    output logic [1:0]       DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_sh;   // dividend bits shift out of the MSB, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;    // always < divisor between iterations

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH+1:0] carry;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    assign DBG_STATE = state;

    // Subtract stage: r_shift + ~{0,dvs} + 1 as a ripple chain; the top carry is the quotient bit.
    // The difference's MSB is not needed because a kept difference is always < divisor.
    always_comb begin
        r_shift  = {rem, q_sh[WIDTH-1]};
        sub_b    = ~{1'b0, dvs};
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            carry[i+1] = (r_shift[i] & sub_b[i]) | (carry[i] & (r_shift[i] ^ sub_b[i]));
        end
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = r_shift[i] ^ sub_b[i] ^ carry[i];
        end
        cout     = carry[WIDTH+1];
        rem_next = cout ? diff : r_shift[WIDTH-1:0];
        q_next   = {q_sh[WIDTH-2:0], cout};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            q_sh        <= '0;
            dvs         <= '0;
            rem         <= '0;
            BUSY        <= 1'b0;
            VALID       <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        q_sh        <= DIVIDEND;
                        dvs         <= DIVISOR;
                        rem         <= '0;
                        cnt         <= '0;
                        DIV_BY_ZERO <= (DIVISOR == '0);
                        BUSY        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_sh <= q_next;
                    rem  <= rem_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        QUOTIENT  <= q_next;
                        REMAINDER <= rem_next;
                        VALID     <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div8_restoring_seq.sv
`timescale 1ns/1ps
// Self-checking bench for div8_restoring_seq: directed scenarios plus a
// randomized sweep scored against a plain-arithmetic reference.
module tb_div8_restoring_seq;

    localparam int W      = 8;
    localparam int N_RAND = 10000;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    div8_restoring_seq #(.WIDTH(W)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start),
        .DIVIDEND    (dividend),
        .DIVISOR     (divisor),
        .BUSY        (busy),
        .VALID       (valid),
        .QUOTIENT    (quotient),
        .REMAINDER   (remainder),
        .DIV_BY_ZERO (dbz),
        .DBG_STATE   (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // scoreboard: {div_by_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {W{1'b1}}, a};
        q = a / b;
        r = a % b;
        return {1'b0, q, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = W'($urandom_range(0, 255));
        divisor  = W'($urandom_range(0, 255));
    endtask

    // Counts cycles from the current point until VALID, bounded.
    task automatic wait_valid(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!valid && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        total++;
        if ({busy, valid, dbz} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got busy=%0d valid=%0d dbz=%0d want 0 0 0", busy, valid, dbz);
        end
        total++;
        if ({quotient, remainder} !== '0) begin
            bad++;
            $display("FAIL reset_result got q=%0d r=%0d want 0 0", quotient, remainder);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        drive_start(8'd200, 8'd7);
        wait_valid(lat, bc);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        total++;
        if (bc !== 8) begin
            bad++;
            $display("FAIL basic_busy_cycles got %0d want 8", bc);
        end
        total++;
        if ({dbz, quotient, remainder} !== {1'b0, 8'd28, 8'd4}) begin
            bad++;
            $display("FAIL basic_result got dbz=%0d q=%0d r=%0d want 0 28 4", dbz, quotient, remainder);
        end
        tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_pulse got %0d want 0", valid);
        end
        tick();
        tick();
        total++;
        if ({quotient, remainder} !== {8'd28, 8'd4}) begin
            bad++;
            $display("FAIL basic_hold got q=%0d r=%0d want 28 4", quotient, remainder);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ta [4] = '{8'd255, 8'd5, 8'd0, 8'h80};
        logic [W-1:0] tb [4] = '{8'd1,   8'd9, 8'd3, 8'd0};
        logic [W-1:0] tq [4] = '{8'd255, 8'd0, 8'd0, 8'hFF};
        logic [W-1:0] tr [4] = '{8'd0,   8'd5, 8'd0, 8'h80};
        logic         td [4] = '{1'b0,   1'b0, 1'b0, 1'b1};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            drive_start(ta[i], tb[i]);
            wait_valid(lat, bc);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL edge_latency case=%0d got %0d want 8", i, lat);
            end
            total++;
            if ({dbz, quotient, remainder} !== {td[i], tq[i], tr[i]}) begin
                bad++;
                $display("FAIL edge_result %0d/%0d got dbz=%0d q=%0d r=%0d want %0d %0d %0d",
                         ta[i], tb[i], dbz, quotient, remainder, td[i], tq[i], tr[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        // previous result is 0x80/0 -> q=0xFF r=0x80
        drive_start(8'd100, 8'd3);
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        tick();
        start    = 1'b0;
        total++;
        if ({busy, quotient, remainder} !== {1'b1, 8'hFF, 8'h80}) begin
            bad++;
            $display("FAIL ignore_hold_in_run got busy=%0d q=%0d r=%0d want 1 255 128", busy, quotient, remainder);
        end
        wait_valid(lat, bc);
        total++;
        if (lat + 3 !== 8) begin
            bad++;
            $display("FAIL ignore_latency got %0d want 8", lat + 3);
        end
        total++;
        if ({dbz, quotient, remainder} !== {1'b0, 8'd33, 8'd1}) begin
            bad++;
            $display("FAIL ignore_result got dbz=%0d q=%0d r=%0d want 0 33 1", dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        drive_start(8'd50, 8'd5);
        wait_valid(lat, bc);
        total++;
        if ({quotient, remainder} !== {8'd10, 8'd0}) begin
            bad++;
            $display("FAIL b2b_first got q=%0d r=%0d want 10 0", quotient, remainder);
        end
        drive_start(8'd17, 8'd4);
        total++;
        if ({busy, quotient, remainder} !== {1'b1, 8'd10, 8'd0}) begin
            bad++;
            $display("FAIL b2b_restart got busy=%0d q=%0d r=%0d want 1 10 0", busy, quotient, remainder);
        end
        wait_valid(lat, bc);
        total++;
        if (lat + 1 !== 9) begin
            bad++;
            $display("FAIL b2b_spacing got %0d want 9", lat + 1);
        end
        total++;
        if ({dbz, quotient, remainder} !== {1'b0, 8'd4, 8'd1}) begin
            bad++;
            $display("FAIL b2b_second got dbz=%0d q=%0d r=%0d want 0 4 1", dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int seen;
        drive_start(8'd250, 8'd0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, valid, dbz, quotient, remainder} !== '0) begin
            bad++;
            $display("FAIL midreset_clear got busy=%0d valid=%0d dbz=%0d q=%0d r=%0d want all 0",
                     busy, valid, dbz, quotient, remainder);
        end
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_no_valid got %0d active cycles want 0", seen);
        end
        drive_start(8'd64, 8'd8);
        wait_valid(lat, bc);
        total++;
        if ({lat, dbz, quotient, remainder} !== {32'd8, 1'b0, 8'd8, 8'd0}) begin
            bad++;
            $display("FAIL midreset_fresh got lat=%0d dbz=%0d q=%0d r=%0d want 8 0 8 0",
                     lat, dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W:0] e;
        int lat, bc, gap;
        for (int i = 0; i < N_RAND; i++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(0, 255));
            exp_q.push_back(model(a, b));
            drive_start(a, b);
            wait_valid(lat, bc);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL rand_latency %0d/%0d got %0d want 8", a, b, lat);
            end
            e = exp_q.pop_front();
            total++;
            if ({dbz, quotient, remainder} !== e) begin
                bad++;
                $display("FAIL rand_result %0d/%0d got dbz=%0d q=%0d r=%0d want %0d %0d %0d",
                         a, b, dbz, quotient, remainder, e[2*W], e[2*W-1:W], e[W-1:0]);
            end
            gap = ($urandom_range(0, 31) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) tick();
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rand_scoreboard_left got %0d want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_300_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
